// File: rtl/bottle_intake_sequencer_pkg.sv
// ============================================================================
// Module : bottle_intake_sequencer_pkg
// Brief  : Shared states, reject codes and widths for the bottle intake path.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bottle_intake_sequencer_pkg;

    localparam int DIST_W = 12;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        REQ      = 3'd1,
        WAIT     = 3'd2,
        GAP      = 3'd3,
        CLASSIFY = 3'd4,
        REPORT   = 3'd5,
        ERROR    = 3'd6
    } state_t;

    localparam logic [1:0] ERR_TIMEOUT  = 2'd0;
    localparam logic [1:0] ERR_UNSTABLE = 2'd1;
    localparam logic [1:0] ERR_EMPTY    = 2'd2;
    localparam logic [1:0] ERR_OVERSIZE = 2'd3;

endpackage

`default_nettype wire

// File: rtl/bottle_intake_sequencer_sample_stats.sv
// ============================================================================
// Module : sample_stats
// Brief  : Running sum plus min/max tracker for one batch of distance samples.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sample_stats
    import bottle_intake_sequencer_pkg::*;
#(
    parameter int SUM_W = DIST_W + 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    input  logic              i_load,
    input  logic [DIST_W-1:0] i_sample,
    output logic [SUM_W-1:0]  o_sum,
    output logic [DIST_W-1:0] o_min,
    output logic [DIST_W-1:0] o_max
);

    logic [SUM_W-1:0]  r_sum;
    logic [DIST_W-1:0] r_min;
    logic [DIST_W-1:0] r_max;

    // Clear seeds min high so the first loaded sample always replaces it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sum <= '0;
            r_min <= '0;
            r_max <= '0;
        end else if (i_clear) begin
            r_sum <= '0;
            r_min <= '1;
            r_max <= '0;
        end else if (i_load) begin
            r_sum <= r_sum + SUM_W'(i_sample);
            if (i_sample < r_min) r_min <= i_sample;
            if (i_sample > r_max) r_max <= i_sample;
        end
    end

    assign o_sum = r_sum;
    assign o_min = r_min;
    assign o_max = r_max;

endmodule

`default_nettype wire

// File: rtl/bottle_intake_sequencer.sv
// ============================================================================
// Module : bottle_intake_sequencer
// Brief  : Runs one bottle-acceptance cycle: sample, average, classify, report.
//          Optional single automatic retry: define BOTTLE_RETRY_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bottle_intake_sequencer
    import bottle_intake_sequencer_pkg::*;
#(
    parameter int SAMPLES     = 4,
    parameter int GAP_CYC     = 3000000,
    parameter int TIMEOUT_CYC = 2500000,
    parameter int TOL         = 2,
    parameter int EMPTY_DIST  = 30,
    parameter int T250_LO     = 22,
    parameter int T500_LO     = 15,
    parameter int T1250_LO    = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DIST_W-1:0] distance_in,
    input  logic              meas_valid,
    output logic              meas_req,
    output logic              inc_250,
    output logic              inc_500,
    output logic              inc_1250,
    output logic              error,
    output logic [1:0]        err_code,
    output logic              busy,
    output logic [DIST_W-1:0] last_avg
);

    localparam int c_LOG_S   = $clog2(SAMPLES);
    localparam int c_SUM_W   = DIST_W + c_LOG_S;
    localparam int c_CNT_W   = $clog2(SAMPLES + 1);
    localparam int c_TMR_MAX = (GAP_CYC > TIMEOUT_CYC) ? GAP_CYC : TIMEOUT_CYC;
    localparam int c_TMR_W   = $clog2(c_TMR_MAX + 1);

    localparam logic [DIST_W-1:0] c_TOL   = DIST_W'(TOL);
    localparam logic [DIST_W-1:0] c_EMPTY = DIST_W'(EMPTY_DIST);
    localparam logic [DIST_W-1:0] c_T250  = DIST_W'(T250_LO);
    localparam logic [DIST_W-1:0] c_T500  = DIST_W'(T500_LO);
    localparam logic [DIST_W-1:0] c_T1250 = DIST_W'(T1250_LO);

    localparam logic [1:0] c_SZ_250  = 2'd0;
    localparam logic [1:0] c_SZ_500  = 2'd1;
    localparam logic [1:0] c_SZ_1250 = 2'd2;

    state_t              r_state;
    state_t              w_next_state;
    logic                r_start_d;
    logic                w_start_rise;
    logic [c_TMR_W-1:0]  r_timer;
    logic [c_CNT_W-1:0]  r_count;
    logic                r_error;
    logic [1:0]          r_err_code;
    logic [DIST_W-1:0]   r_last_avg;
    logic [1:0]          r_size;

    logic                w_clear;
    logic                w_load;
    logic                w_fail;
    logic [1:0]          w_fail_code;
    logic                w_cls_fail;
    logic [1:0]          w_cls_code;
    logic [1:0]          w_cls_size;

    logic [c_SUM_W-1:0]  w_sum;
    logic [DIST_W-1:0]   w_min;
    logic [DIST_W-1:0]   w_max;
    logic [DIST_W-1:0]   w_avg;
    logic [DIST_W-1:0]   w_spread;

`ifdef BOTTLE_RETRY_EN
    logic                r_retried;
    logic                w_retry;
`endif

    assign w_start_rise = start & ~r_start_d;
    assign w_avg        = w_sum[c_SUM_W-1:c_LOG_S];
    assign w_spread     = w_max - w_min;

    sample_stats #(
        .SUM_W (c_SUM_W)
    ) u_stats (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_clear),
        .i_load   (w_load),
        .i_sample (distance_in),
        .o_sum    (w_sum),
        .o_min    (w_min),
        .o_max    (w_max)
    );

    // Priority-ordered classification of the finished batch.
    always_comb begin
        w_cls_fail = 1'b0;
        w_cls_code = ERR_TIMEOUT;
        w_cls_size = c_SZ_1250;
        if (w_spread > c_TOL) begin
            w_cls_fail = 1'b1;
            w_cls_code = ERR_UNSTABLE;
        end else if (w_avg >= c_EMPTY) begin
            w_cls_fail = 1'b1;
            w_cls_code = ERR_EMPTY;
        end else if (w_avg < c_T1250) begin
            w_cls_fail = 1'b1;
            w_cls_code = ERR_OVERSIZE;
        end else if (w_avg >= c_T250) begin
            w_cls_size = c_SZ_250;
        end else if (w_avg >= c_T500) begin
            w_cls_size = c_SZ_500;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_clear      = 1'b0;
        w_load       = 1'b0;
        w_fail       = 1'b0;
        w_fail_code  = ERR_TIMEOUT;
`ifdef BOTTLE_RETRY_EN
        w_retry      = 1'b0;
`endif
        case (r_state)
            IDLE, ERROR: begin
                if (w_start_rise) begin
                    w_clear      = 1'b1;
                    w_next_state = REQ;
                end
            end
            REQ: w_next_state = WAIT;
            WAIT: begin
                // A sample arriving on the expiry cycle still counts.
                if (meas_valid) begin
                    w_load       = 1'b1;
                    w_next_state = (r_count == c_CNT_W'(SAMPLES - 1)) ? CLASSIFY : GAP;
                end else if (r_timer == '0) begin
                    w_fail      = 1'b1;
                    w_fail_code = ERR_TIMEOUT;
                end
            end
            GAP: begin
                if (r_timer == '0) w_next_state = REQ;
            end
            CLASSIFY: begin
                if (w_cls_fail) begin
                    w_fail      = 1'b1;
                    w_fail_code = w_cls_code;
                end else begin
                    w_next_state = REPORT;
                end
            end
            REPORT: w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase

`ifdef BOTTLE_RETRY_EN
        if (w_fail && !r_retried &&
            (w_fail_code == ERR_TIMEOUT || w_fail_code == ERR_UNSTABLE)) begin
            w_retry      = 1'b1;
            w_clear      = 1'b1;
            w_next_state = GAP;
        end else if (w_fail) begin
            w_next_state = ERROR;
        end
`else
        if (w_fail) w_next_state = ERROR;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_start_d  <= 1'b0;
            r_timer    <= '0;
            r_count    <= '0;
            r_error    <= 1'b0;
            r_err_code <= ERR_TIMEOUT;
            r_last_avg <= '0;
            r_size     <= c_SZ_250;
        end else begin
            r_state   <= w_next_state;
            r_start_d <= start;

            // The timer is shared: timeout while in WAIT, spacing while in GAP.
            if (r_state == REQ)
                r_timer <= c_TMR_W'(TIMEOUT_CYC - 1);
            else if (w_next_state == GAP && r_state != GAP)
                r_timer <= c_TMR_W'(GAP_CYC - 1);
            else if (r_timer != '0)
                r_timer <= r_timer - c_TMR_W'(1);

            if (w_clear)
                r_count <= '0;
            else if (w_load)
                r_count <= r_count + c_CNT_W'(1);

            if (w_fail && w_next_state == ERROR) begin
                r_error    <= 1'b1;
                r_err_code <= w_fail_code;
            end else if (r_state == ERROR && w_start_rise) begin
                r_error    <= 1'b0;
                r_err_code <= ERR_TIMEOUT;
            end

            if (r_state == CLASSIFY) begin
                r_last_avg <= w_avg;
                r_size     <= w_cls_size;
            end
        end
    end

`ifdef BOTTLE_RETRY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_retried <= 1'b0;
        else if (w_retry)
            r_retried <= 1'b1;
        else if ((r_state == IDLE || r_state == ERROR) && w_start_rise)
            r_retried <= 1'b0;
    end
`endif

    assign meas_req = (r_state == REQ);
    assign inc_250  = (r_state == REPORT) && (r_size == c_SZ_250);
    assign inc_500  = (r_state == REPORT) && (r_size == c_SZ_500);
    assign inc_1250 = (r_state == REPORT) && (r_size == c_SZ_1250);
    assign error    = r_error;
    assign err_code = r_err_code;
    assign busy     = (r_state != IDLE) && (r_state != ERROR);
    assign last_avg = r_last_avg;

endmodule

`default_nettype wire

// File: tb/tb_bottle_intake_sequencer.sv
// ============================================================================
// Module : tb_bottle_intake_sequencer
// Brief  : Directed self-checking bench for bottle_intake_sequencer.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bottle_intake_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [11:0] distance_in;
    logic        meas_valid;
    logic        meas_req;
    logic        inc_250;
    logic        inc_500;
    logic        inc_1250;
    logic        error;
    logic [1:0]  err_code;
    logic        busy;
    logic [11:0] last_avg;

    int total = 0;
    int bad   = 0;

    int cyc = 0, n250 = 0, n500 = 0, n1250 = 0, nreq = 0;
    int last_req_cyc = 0, err_rise_cyc = 0;
    logic err_q = 1'b0;

    logic [11:0] q [$];

    bottle_intake_sequencer #(
        .SAMPLES     (4),
        .GAP_CYC     (4),
        .TIMEOUT_CYC (50)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .distance_in (distance_in),
        .meas_valid  (meas_valid),
        .meas_req    (meas_req),
        .inc_250     (inc_250),
        .inc_500     (inc_500),
        .inc_1250    (inc_1250),
        .error       (error),
        .err_code    (err_code),
        .busy        (busy),
        .last_avg    (last_avg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (inc_250)  n250  <= n250 + 1;
        if (inc_500)  n500  <= n500 + 1;
        if (inc_1250) n1250 <= n1250 + 1;
        if (meas_req) begin
            nreq         <= nreq + 1;
            last_req_cyc <= cyc;
        end
        if (error && !err_q) err_rise_cyc <= cyc;
        err_q <= error;
    end

    // Sensor model: answers each request two cycles later from the queue.
    initial begin
        logic [11:0] d;
        meas_valid  = 1'b0;
        distance_in = '0;
        forever begin
            @(negedge clk);
            if (rst && meas_req && q.size() > 0) begin
                d = q.pop_front();
                repeat (2) @(negedge clk);
                distance_in = d;
                meas_valid  = 1'b1;
                @(negedge clk);
                meas_valid  = 1'b0;
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            total++; bad++;
            $display("FAIL wait_idle: busy=%0b after %0d cycles, required 0", busy, n);
        end
        @(negedge clk);
    endtask

    task automatic run_bottle(input logic [11:0] s0, input logic [11:0] s1,
                              input logic [11:0] s2, input logic [11:0] s3);
        q.push_back(s0); q.push_back(s1); q.push_back(s2); q.push_back(s3);
        pulse_start();
        wait_idle();
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({meas_req, inc_250, inc_500, inc_1250, error, err_code, busy, last_avg} !== 20'h0) begin
            bad++;
            $display("FAIL reset_outputs: got %h required 0",
                     {meas_req, inc_250, inc_500, inc_1250, error, err_code, busy, last_avg});
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_bands();
        logic [11:0] smp [0:6][0:3] = '{
            '{12'd25, 12'd25, 12'd26, 12'd24},
            '{12'd15, 12'd15, 12'd15, 12'd15},
            '{12'd14, 12'd14, 12'd14, 12'd14},
            '{12'd22, 12'd22, 12'd22, 12'd22},
            '{12'd21, 12'd21, 12'd21, 12'd21},
            '{12'd5,  12'd5,  12'd5,  12'd5 },
            '{12'd29, 12'd29, 12'd30, 12'd29}};
        logic [11:0] exp_avg [0:6] = '{12'd25, 12'd15, 12'd14, 12'd22, 12'd21, 12'd5, 12'd29};
        logic [2:0]  exp_inc [0:6] = '{3'b100, 3'b010, 3'b001, 3'b100, 3'b010, 3'b001, 3'b100};
        for (int i = 0; i < 7; i++) begin
            int a = n250, b = n500, c = n1250;
            logic [2:0] got;
            run_bottle(smp[i][0], smp[i][1], smp[i][2], smp[i][3]);
            got = {(n250 - a) == 1, (n500 - b) == 1, (n1250 - c) == 1};
            total++;
            if (got !== exp_inc[i] || (n250 - a + n500 - b + n1250 - c) != 1) begin
                bad++;
                $display("FAIL band_inc[%0d]: got 250/500/1250 pulses %0d/%0d/%0d required %b",
                         i, n250 - a, n500 - b, n1250 - c, exp_inc[i]);
            end
            total++;
            if (last_avg !== exp_avg[i]) begin
                bad++;
                $display("FAIL band_avg[%0d]: got %0d required %0d", i, last_avg, exp_avg[i]);
            end
            total++;
            if (error !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL band_flags[%0d]: error=%b busy=%b required 0/0", i, error, busy);
            end
        end
    endtask

    task automatic test_rejects();
        logic [11:0] val  [0:1] = '{12'd30, 12'd4};
        logic [1:0]  code [0:1] = '{2'd2, 2'd3};
        for (int i = 0; i < 2; i++) begin
            int s = n250 + n500 + n1250;
            run_bottle(val[i], val[i], val[i], val[i]);
            total++;
            if (error !== 1'b1 || err_code !== code[i]) begin
                bad++;
                $display("FAIL reject[%0d]: error=%b code=%0d required 1/%0d", i, error, err_code, code[i]);
            end
            total++;
            if (n250 + n500 + n1250 != s) begin
                bad++;
                $display("FAIL reject_inc[%0d]: got %0d pulses required 0", i, n250 + n500 + n1250 - s);
            end
        end
    endtask

    task automatic test_unstable();
        int s = n250 + n500 + n1250, c = n1250, r = nreq;
`ifdef BOTTLE_RETRY_EN
        q.push_back(12'd10); q.push_back(12'd10); q.push_back(12'd14); q.push_back(12'd10);
        run_bottle(12'd10, 12'd10, 12'd10, 12'd10);
        total++;
        if (error !== 1'b0 || (n1250 - c) != 1 || (n250 + n500 + n1250 - s) != 1) begin
            bad++;
            $display("FAIL unstable_retry: error=%b inc_1250=%0d required 0/1", error, n1250 - c);
        end
        total++;
        if (nreq - r != 8) begin
            bad++;
            $display("FAIL unstable_reqs: got %0d required 8", nreq - r);
        end
`else
        run_bottle(12'd10, 12'd10, 12'd14, 12'd10);
        total++;
        if (error !== 1'b1 || err_code !== 2'd1 || (n250 + n500 + n1250) != s) begin
            bad++;
            $display("FAIL unstable: error=%b code=%0d pulses=%0d required 1/1/0",
                     error, err_code, n250 + n500 + n1250 - s);
        end
        total++;
        if (nreq - r != 4 || c != n1250) begin
            bad++;
            $display("FAIL unstable_reqs: got %0d required 4", nreq - r);
        end
`endif
    endtask

    task automatic test_timeout();
        int r = nreq, b = n500, exp_req;
`ifdef BOTTLE_RETRY_EN
        exp_req = 2;
`else
        exp_req = 1;
`endif
        pulse_start();
        wait_idle();
        total++;
        if (error !== 1'b1 || err_code !== 2'd0) begin
            bad++;
            $display("FAIL timeout: error=%b code=%0d required 1/0", error, err_code);
        end
        total++;
        if (nreq - r != exp_req) begin
            bad++;
            $display("FAIL timeout_reqs: got %0d required %0d", nreq - r, exp_req);
        end
        total++;
        if (err_rise_cyc - last_req_cyc < 50 || err_rise_cyc - last_req_cyc > 52) begin
            bad++;
            $display("FAIL timeout_delay: got %0d cycles required 50..52", err_rise_cyc - last_req_cyc);
        end
        r = nreq;
        q.push_back(12'd20); q.push_back(12'd20); q.push_back(12'd20); q.push_back(12'd20);
        pulse_start();
        total++;
        if (error !== 1'b0 || nreq == r) begin
            bad++;
            $display("FAIL timeout_clear: error=%b new_reqs=%0d required 0/>0", error, nreq - r);
        end
        wait_idle();
        total++;
        if (n500 - b != 1 || error !== 1'b0) begin
            bad++;
            $display("FAIL timeout_recover: inc_500=%0d error=%b required 1/0", n500 - b, error);
        end
    endtask

    task automatic test_back_to_back();
        int a = n250, s = n250 + n500 + n1250, r = nreq;
        q.push_back(12'd25); q.push_back(12'd25); q.push_back(12'd25); q.push_back(12'd25);
        pulse_start();
        repeat (3) pulse_start();
        wait_idle();
        repeat (80) @(negedge clk);
        total++;
        if (n250 - a != 1 || n250 + n500 + n1250 - s != 1) begin
            bad++;
            $display("FAIL busy_start_inc: got %0d pulses required 1", n250 + n500 + n1250 - s);
        end
        total++;
        if (nreq - r != 4 || error !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL busy_start_reqs: reqs=%0d error=%b busy=%b required 4/0/0",
                     nreq - r, error, busy);
        end
    endtask

    task automatic test_reset_midcycle();
        int s;
        pulse_start();
        s = n250 + n500 + n1250;
        rst = 1'b0;
        #1;
        total++;
        if ({meas_req, inc_250, inc_500, inc_1250, error, err_code, busy, last_avg} !== 20'h0) begin
            bad++;
            $display("FAIL reset_mid: got %h required 0",
                     {meas_req, inc_250, inc_500, inc_1250, error, err_code, busy, last_avg});
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (80) @(negedge clk);
        total++;
        if (n250 + n500 + n1250 != s || busy !== 1'b0 || error !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_after: pulses=%0d busy=%b error=%b required 0/0/0",
                     n250 + n500 + n1250 - s, busy, error);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_bands();
        test_rejects();
        test_unstable();
        test_timeout();
        test_back_to_back();
        test_reset_midcycle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
